unidade_controle_multiciclo: RTL

UNIDADE_CONTROLE_MULTICICLO -- requirements
Module: unidade_controle_multiciclo

---
 rtl/unidade_controle_multiciclo.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/unidade_controle_multiciclo.sv
// rtl/unidade_controle_multiciclo.sv - multicycle control unit FSM for an RV32 subset datapath
module unidade_controle_multiciclo (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        mem_pronta,
  output logic        escreve_pc,
  output logic        escreve_pc_desvio,
  output logic        escreve_ir,
  output logic        le_mem,
  output logic        escreve_mem,
  output logic        iord,
  output logic        escreve_reg,
  output logic        mem_para_reg,
  output logic [1:0]  ula_src_b,
  output logic [1:0]  op_ula,
  output logic        desvio_beq,
  output logic        desvio_bne,
  output logic [3:0]  estado,
  output logic        instr_ilegal,
  output logic [31:0] instrucoes_concluidas
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    BUSCA          = 4'd0,
    DECODIFICA     = 4'd1,
    EXEC_R         = 4'd2,
    EXEC_I         = 4'd3,
    CALC_END       = 4'd4,
    ACESSO_LE      = 4'd5,
    ACESSO_ESCREVE = 4'd6,
    ESCRITA_REG    = 4'd7,
    DESVIO         = 4'd8,
    PARADO         = 4'd9
  } estado_t;

  estado_t estado_atual, estado_prox;
  logic    veio_de_leitura;
  logic    retira;

  assign estado = estado_atual;

  // State register; reset abandons any access in flight and restarts at fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado_atual <= BUSCA;
    else     estado_atual <= estado_prox;
  end

  // Load flag, sticky illegal flag and retired-instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      veio_de_leitura       <= 1'b0;
      instr_ilegal          <= 1'b0;
      instrucoes_concluidas <= 32'd0;
    end else begin
      if (estado_atual == ACESSO_LE)  veio_de_leitura <= 1'b1;
      else if (estado_atual == BUSCA) veio_de_leitura <= 1'b0;
      if (estado_prox == PARADO) instr_ilegal <= 1'b1;
      if (retira) instrucoes_concluidas <= instrucoes_concluidas + 32'd1;
    end
  end

  // Next-state and control outputs; outputs forced low while reset is held
  always_comb begin
    estado_prox       = estado_atual;
    retira            = 1'b0;
    escreve_pc        = 1'b0;
    escreve_pc_desvio = 1'b0;
    escreve_ir        = 1'b0;
    le_mem            = 1'b0;
    escreve_mem       = 1'b0;
    iord              = 1'b0;
    escreve_reg       = 1'b0;
    mem_para_reg      = 1'b0;
    ula_src_b         = 2'b00;
    op_ula            = 2'b00;
    desvio_beq        = 1'b0;
    desvio_bne        = 1'b0;
    case (estado_atual)
      BUSCA: begin
        le_mem = 1'b1;
        if (mem_pronta) begin
          escreve_ir  = 1'b1;
          escreve_pc  = 1'b1;
          estado_prox = DECODIFICA;
        end
      end
      DECODIFICA: begin
        case (opcode)
          OP_R:               estado_prox = EXEC_R;
          OP_I:               estado_prox = EXEC_I;
          OP_LOAD, OP_STORE:  estado_prox = CALC_END;
          OP_BRANCH:          estado_prox = DESVIO;
          default:            estado_prox = PARADO;
        endcase
      end
      EXEC_R: begin
        ula_src_b   = 2'b00;
        op_ula      = 2'b10;
        estado_prox = ESCRITA_REG;
      end
      EXEC_I: begin
        ula_src_b   = 2'b10;
        op_ula      = 2'b00;
        estado_prox = ESCRITA_REG;
      end
      CALC_END: begin
        ula_src_b   = 2'b10;
        op_ula      = 2'b01;
        estado_prox = (opcode == OP_LOAD) ? ACESSO_LE : ACESSO_ESCREVE;
      end
      ACESSO_LE: begin
        le_mem = 1'b1;
        iord   = 1'b1;
        if (mem_pronta) estado_prox = ESCRITA_REG;
      end
      ACESSO_ESCREVE: begin
        escreve_mem = 1'b1;
        iord        = 1'b1;
        if (mem_pronta) begin
          estado_prox = BUSCA;
          retira      = 1'b1;
        end
      end
      ESCRITA_REG: begin
        escreve_reg  = 1'b1;
        mem_para_reg = veio_de_leitura;
        estado_prox  = BUSCA;
        retira       = 1'b1;
      end
      DESVIO: begin
        // PC already holds PC+4 here; the datapath uses its latched old PC
        ula_src_b         = 2'b00;
        op_ula            = 2'b11;
        escreve_pc_desvio = 1'b1;
        if (funct3 == 3'b001) desvio_bne = 1'b1;
        else                  desvio_beq = 1'b1;
        estado_prox = BUSCA;
        retira      = 1'b1;
      end
      PARADO: begin
        estado_prox = PARADO;
      end
      default: begin
        estado_prox = BUSCA;
      end
    endcase
    if (rst) begin
      escreve_pc        = 1'b0;
      escreve_pc_desvio = 1'b0;
      escreve_ir        = 1'b0;
      le_mem            = 1'b0;
      escreve_mem       = 1'b0;
      iord              = 1'b0;
      escreve_reg       = 1'b0;
      mem_para_reg      = 1'b0;
      ula_src_b         = 2'b00;
      op_ula            = 2'b00;
      desvio_beq        = 1'b0;
      desvio_bne        = 1'b0;
    end
  end

endmodule
